uart_tx_dump: RTL and testbench

- UART transmitter that reads back the channel configuration RAM and streams it to the PC on request.
- Opposite direction of the UART receive path: the receiver writes the RAM and this block reads it.
- On a dump request it sends DUMP_LEN bytes from RAM address 0 upward as 8N1 frames, then sends one XOR checksum byte.
- The PC uses the dump to confirm that the Pulse/Delay channel settings were stored correctly before a run.

---
 rtl/uart_tx_dump.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_dump.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dump.sv
// Dump transmitter: streams DUMP_LEN bytes of the channel configuration RAM as 8N1 frames,
// followed by one XOR checksum frame of those bytes.
module uart_tx_dump #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DUMP_LEN     = 40,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic       clk_Tx,
    input  logic       rst,
    input  logic       dump_start,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       Tx,
    output logic       busy,
    output logic       done
);

    // state       | meaning
    // S_IDLE      | line idle, waiting for dump_start
    // S_FETCH     | address presented, waiting out RAM latency
    // S_LOAD      | capture rd_data into shifter, fold into checksum
    // S_START     | start bit
    // S_DATA      | eight data bits
    // S_STOP      | stop bit, then pick next byte / checksum / finish
    // S_CSUM_LOAD | two cycles, load checksum into shifter
    // S_FINISH    | pulse done, release busy
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP, S_CSUM_LOAD, S_FINISH
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  LAST_ADDR = 8'(DUMP_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  addr_q, addr_d;
    logic        csum_phase_q, csum_phase_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_Tx) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= 16'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            csum_q       <= 8'h00;
            addr_q       <= 8'h00;
            csum_phase_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            addr_q       <= addr_d;
            csum_phase_q <= csum_phase_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Line level is registered from the current state, so Tx trails the state by one cycle.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        addr_d       = addr_q;
        csum_phase_d = csum_phase_q;
        busy_d       = busy_q;
        tx_d         = 1'b1;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    busy_d       = 1'b1;
                    addr_d       = 8'h00;
                    csum_d       = 8'h00;
                    csum_phase_d = 1'b0;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = rd_data;
                csum_d  = csum_q ^ rd_data;
                baud_d  = 16'd0;
                state_d = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                tx_d = MSB_FIRST ? shift_q[7] : shift_q[0];
                if (baud_last) begin
                    baud_d  = 16'd0;
                    shift_d = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = 16'd0;
                    if (csum_phase_q) begin
                        state_d = S_FINISH;
                    end else if (addr_q == LAST_ADDR) begin
                        csum_phase_d = 1'b1;
                        state_d      = S_CSUM_LOAD;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_CSUM_LOAD: begin
                // Baud counter enters at 0 and reuses it to stretch this state to two cycles.
                if (baud_q == 16'd1) begin
                    shift_d = csum_q;
                    baud_d  = 16'd0;
                    state_d = S_START;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = 8'h00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_addr = addr_q;
    assign Tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_dump.sv
// Scoreboard bench for uart_tx_dump: three instances (MSB/LEN=3, LSB/LEN=1, MSB/LEN=256),
// a frame decoder per line and an expected-byte queue per instance.
module tb_uart_tx_dump;

    localparam int C  = 4;
    localparam int NI = 3;
    localparam int LEN_K [NI] = '{3, 1, 256};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]      rst = '1;
    logic [NI-1:0]      dump_start = '0;
    logic [NI-1:0]      tx, busy, done;
    logic [NI-1:0][7:0] rd_addr;
    logic [NI-1:0][7:0] rd_data;

    logic [7:0] ram   [NI][256];
    logic [7:0] exp_q [NI][$];
    int mon_cnt  [NI] = '{-1, -1, -1};
    logic [7:0] mon_byte [NI];
    int done_cnt [NI] = '{0, 0, 0};
    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_dump #(.CLKS_PER_BIT(C), .DUMP_LEN(3), .MSB_FIRST(1'b1)) u_dut0 (
        .clk_Tx(clk), .rst(rst[0]), .dump_start(dump_start[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .Tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_dump #(.CLKS_PER_BIT(C), .DUMP_LEN(1), .MSB_FIRST(1'b0)) u_dut1 (
        .clk_Tx(clk), .rst(rst[1]), .dump_start(dump_start[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .Tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_dump #(.CLKS_PER_BIT(C), .DUMP_LEN(256), .MSB_FIRST(1'b1)) u_dut2 (
        .clk_Tx(clk), .rst(rst[2]), .dump_start(dump_start[2]), .rd_addr(rd_addr[2]),
        .rd_data(rd_data[2]), .Tx(tx[2]), .busy(busy[2]), .done(done[2]));

    // Registered RAM: data for an address appears one clock later.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) rd_data[k] <= ram[k][rd_addr[k]];
    end

    function automatic void check(input string name, input int k, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, want %0h", name, k, act, req);
        end
    endfunction

    // Line decoder: samples each bit at its centre, aborts a frame on reset.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (done[k]) done_cnt[k]++;
            if (rst[k]) begin
                mon_cnt[k] = -1;
            end else if (mon_cnt[k] < 0) begin
                if (!tx[k]) begin
                    mon_cnt[k]  = 0;
                    mon_byte[k] = 8'h00;
                end
            end else begin
                mon_cnt[k]++;
                if (mon_cnt[k] % C == C / 2) begin
                    int slot;
                    slot = mon_cnt[k] / C;
                    if (slot == 0) begin
                        check("start_bit", k, tx[k], 0);
                    end else if (slot <= 8) begin
                        if (k != 1) mon_byte[k] = {mon_byte[k][6:0], tx[k]};
                        else        mon_byte[k] = {tx[k], mon_byte[k][7:1]};
                    end else begin
                        check("stop_bit", k, tx[k], 1);
                        n_cmp++;
                        if (exp_q[k].size() == 0) begin
                            n_bad++;
                            $display("FAIL frame[%0d]: got unexpected byte %02h, want no frame", k, mon_byte[k]);
                        end else begin
                            logic [7:0] want;
                            want = exp_q[k].pop_front();
                            if (mon_byte[k] != want) begin
                                n_bad++;
                                $display("FAIL frame[%0d]: got %02h, want %02h", k, mon_byte[k], want);
                            end
                        end
                        mon_cnt[k] = -1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the dump is the RAM image in address order plus the XOR of those bytes.
    task automatic expect_dump(input int k);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < LEN_K[k]; i++) begin
            exp_q[k].push_back(ram[k][i]);
            cs ^= ram[k][i];
        end
        exp_q[k].push_back(cs);
    endtask

    task automatic run_dump(input int k, input int extra_at);
        int total, cyc, t_fall, peak, nseq, last, dones0;
        bit seq_ok;
        total  = 1 + (LEN_K[k] + 1) * (10 * C + 2);
        expect_dump(k);
        dones0 = done_cnt[k];
        dump_start[k] = 1'b1;
        tick();
        dump_start[k] = 1'b0;
        check("busy_set", k, busy[k], 1);
        cyc = 0; t_fall = -1; peak = 0; nseq = 1; last = 0;
        seq_ok = (rd_addr[k] == 8'h00);
        while (cyc < total + 20) begin
            tick();
            cyc++;
            dump_start[k] = (cyc == extra_at);
            if (done[k]) break;
            if (t_fall < 0 && !tx[k]) t_fall = cyc;
            if (int'(rd_addr[k]) != last) begin
                seq_ok &= (int'(rd_addr[k]) == last + 1);
                last = int'(rd_addr[k]);
                nseq++;
            end
            if (int'(rd_addr[k]) > peak) peak = int'(rd_addr[k]);
        end
        dump_start[k] = 1'b0;
        check("done_cycle", k, cyc, total);
        check("first_fall", k, t_fall, 3);
        check("addr_seq", k, seq_ok, 1);
        check("addr_count", k, nseq, LEN_K[k]);
        check("addr_peak", k, peak, LEN_K[k] - 1);
        check("addr_clear", k, rd_addr[k], 0);
        check("busy_clear", k, busy[k], 0);
        tick();
        check("done_width", k, done[k], 0);
        repeat (10) tick();
        check("frames_left", k, exp_q[k].size(), 0);
        check("done_count", k, done_cnt[k] - dones0, 1);
        check("no_restart", k, busy[k], 0);
    endtask

    initial begin
        int bad_tx, dones0;

        // Reset state and idle line
        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            check("rst_tx", k, tx[k], 1);
            check("rst_busy", k, busy[k], 0);
            check("rst_done", k, done[k], 0);
            check("rst_addr", k, rd_addr[k], 0);
        end
        rst = '0;
        bad_tx = 0;
        repeat (100) begin
            tick();
            if (tx != '1) bad_tx++;
        end
        check("idle_tx", 0, bad_tx, 0);

        // Basic dump with known bytes, then a late request in the FINISH cycle
        ram[0][0] = 8'hA5; ram[0][1] = 8'h3C; ram[0][2] = 8'h01;
        run_dump(0, -1);
        run_dump(0, 1 + 4 * (10 * C + 2) - 1);

        // MSB-first with the top bit set, then random bytes with a mid-dump request
        ram[0][0] = 8'h80; ram[0][1] = 8'h00; ram[0][2] = 8'hFF;
        run_dump(0, -1);
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) ram[0][i] = 8'($urandom);
            run_dump(0, int'($urandom_range(5, 150)));
        end

        // LSB-first, single byte
        ram[1][0] = 8'h80;
        run_dump(1, -1);
        for (int r = 0; r < 4; r++) begin
            ram[1][0] = 8'($urandom);
            run_dump(1, -1);
        end

        // Request coincident with reset is dropped
        rst[0] = 1'b1; dump_start[0] = 1'b1;
        tick();
        rst[0] = 1'b0; dump_start[0] = 1'b0;
        bad_tx = 0;
        repeat (30) begin
            tick();
            if (busy[0] || !tx[0]) bad_tx++;
        end
        check("rst_wins", 0, bad_tx, 0);

        // Reset during a data bit of the second frame
        for (int i = 0; i < 3; i++) ram[0][i] = 8'($urandom);
        expect_dump(0);
        dump_start[0] = 1'b1;
        tick();
        dump_start[0] = 1'b0;
        repeat (60) tick();
        check("mid_busy", 0, busy[0], 1);
        rst[0] = 1'b1;
        exp_q[0].delete();
        dones0 = done_cnt[0];
        tick();
        check("abort_tx", 0, tx[0], 1);
        check("abort_busy", 0, busy[0], 0);
        check("abort_done", 0, done[0], 0);
        rst[0] = 1'b0;
        repeat (200) tick();
        check("abort_no_done", 0, done_cnt[0] - dones0, 0);
        for (int i = 0; i < 3; i++) ram[0][i] = 8'($urandom);
        run_dump(0, -1);

        // Full 256-byte dump of an address ramp
        for (int i = 0; i < 256; i++) ram[2][i] = 8'(i);
        run_dump(2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
